// File: rtl/alu_mdu.sv
// Handshaked ALU with single-cycle logic/arith ops and iterative multiply/divide.
// Multi-cycle ops run one bit per cycle for exactly WIDTH cycles, with no early exit.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res,
  output logic             zero,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_SLTU = 4'b0111,
                         OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_XOR  = 4'b0011,
                         OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SRA  = 4'b1000,
                         OP_SLT = 4'b1001, OP_MUL = 4'b1010, OP_DIVU = 4'b1011,
                         OP_REMU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  // Valid/ready: a transfer happens on any rising edge where valid && ready are both
  // high; the producer holds its payload stable until then, and ready never waits on valid.
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign Res       = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   sh;

  always_comb begin
    sum     = A + B;
    diff    = A - B;
    sh      = B[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (OP)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: alu_res[0] = (A < B);
      OP_SLT:  alu_res[0] = ($signed(A) < $signed(B));
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLL:  alu_res = A << sh;
      OP_SRL:  alu_res = A >> sh;
      OP_SRA:  alu_res = $signed(A) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // acc holds {product_hi, multiplier} for MUL and {remainder, quotient} for DIVU/REMU.
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, iter_next;
  logic [WIDTH-1:0]   iter_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    iter_next = (op_q == OP_MUL) ? mul_next : div_next;
    iter_res  = (op_q == OP_REMU) ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready && !in_valid) state_d = S_IDLE;
        if (in_valid && in_ready) begin
          op_d = OP;
          if (OP == OP_MUL || OP == OP_DIVU || OP == OP_REMU) begin
            state_d = S_BUSY;
            cnt_d   = CNTW'(WIDTH);
            b_d     = B;
            acc_d   = {{WIDTH{1'b0}}, A};
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNTW'(1);
        acc_d = iter_next;
        if (cnt_q == CNTW'(1)) begin
          state_d = S_DONE;
          res_d   = iter_res;
          zero_d  = (iter_res == '0);
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32: single-cycle ops, iterative MUL/DIV timing,
// hold behaviour, reset abort and a back-to-back ADD stream.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [3:0]  op_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        zero;
  logic        ovf;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .OP(op_in), .out_valid(out_valid), .out_ready(out_ready),
    .Res(res), .zero(zero), .ovf(ovf), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = 1'b1; op_in = op; a_in = a; b_in = b;
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".idle"}, out_valid, 1'b0);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res,
                            input logic exp_ovf);
    issue(tag, op, a, b);
    check_eq({tag, ".valid"}, out_valid, 1'b1);
    check_eq({tag, ".res"}, res, exp_res);
    check_eq({tag, ".zero"}, zero, exp_res == 32'd0);
    check_eq({tag, ".ovf"}, ovf, exp_ovf);
    retire(tag);
  endtask

  // Waits for out_valid while poking in_valid/out_ready, which BUSY must ignore.
  task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int hold);
    int cycles;
    int rdy_seen;
    issue(tag, op, a, b);
    cycles = 1;
    rdy_seen = 0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) rdy_seen++;
      in_valid = 1'b1; op_in = 4'b0010; a_in = 32'h1234; b_in = 32'h1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq({tag, ".latency"}, cycles, 33);
    check_eq({tag, ".busy_ready"}, rdy_seen, 0);
    check_eq({tag, ".res"}, res, exp_res);
    check_eq({tag, ".zero"}, zero, exp_res == 32'd0);
    check_eq({tag, ".ovf"}, ovf, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op_in = 4'b0010;
      @(posedge clk); #1;
      check_eq({tag, ".hold_valid"}, out_valid, 1'b1);
      check_eq({tag, ".hold_res"}, res, exp_res);
    end
    in_valid = 1'b0;
    retire(tag);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.res", res, 32'd0);
    check_eq("rst.zero", zero, 1'b1);
    check_eq("rst.ovf", ovf, 1'b0);
    check_eq("rst.valid", out_valid, 1'b0);
    check_eq("rst.state", dbg_state, 2'd0);
    reset = 1'b0;
    check_eq("rst.in_ready", in_ready, 1'b1);

    run_single("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    run_single("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);
    run_single("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
    run_single("and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
    run_single("sub_neg",  4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0);
    run_single("slt",      4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0);
    run_single("sltu",     4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    run_single("or",       4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
    run_single("xor",      4'b0011, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0);
    run_single("sll31",    4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0);
    run_single("sll_mask", 4'b0100, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0);
    run_single("srl",      4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
    run_single("sra",      4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
    run_single("nop",      4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0);
    run_single("undef",    4'b1101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0);

    run_multi("mul7x6",   4'b1010, 32'd7, 32'd6, 32'd42, 5);
    run_multi("mul_ones", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    run_multi("divu",     4'b1011, 32'd100, 32'd7, 32'd14, 0);
    run_multi("remu",     4'b1100, 32'd100, 32'd7, 32'd2, 0);
    run_multi("divu_z",   4'b1011, 32'd100, 32'd0, 32'hFFFFFFFF, 0);
    run_multi("remu_z",   4'b1100, 32'd100, 32'd0, 32'd100, 0);
    run_multi("remu_0",   4'b1100, 32'd14, 32'd7, 32'd0, 0);
    run_multi("divu_big", 4'b1011, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 0);

    // Reset one cycle into the 10th cycle of a DIVU drops it without a result.
    issue("rst_div", 4'b1011, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("rst_div.valid", out_valid, 1'b0);
    check_eq("rst_div.res", res, 32'd0);
    check_eq("rst_div.in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("rst_div.no_result", seen, 0);

    // Back-to-back ADD stream, one result per clock.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = 32'h10000001 * i + 32'hFFFFFFF0;
      b = i + 3;
      in_valid = 1'b1; op_in = 4'b0010; a_in = a; b_in = b;
      exp_q.push_back(a + b);
      check_eq("stream.in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      check_eq("stream.valid", out_valid, 1'b1);
      check_eq("stream.res", res, exp_q.pop_front());
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("stream.idle", out_valid, 1'b0);
    check_eq("stream.drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 OP  input  4  opcode.
REQ-010 out_valid  output  1  Res and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 Res  output  WIDTH  registered result.
REQ-013 zero  output  1  high when Res == 0.
REQ-014 ovf  output  1  signed overflow; meaningful only for ADD and SUB, 0 for every other opcode.

Function
REQ-015 OP encoding:
- 0010 ADD
- 0110 SUB
- 0111 SLTU (unsigned A<B -> 1, else 0)
- 0000 AND
- 0001 OR
- 1111 NOP (Res=0)
- 0011 XOR
- 0100 SLL by B[log2 WIDTH-1:0]
- 0101 SRL (same shift-amount field)
- 1000 SRA (same shift-amount field)
- 1001 SLT (signed)
- 1010 MUL (low WIDTH bits of the unsigned product)
- 1011 DIVU (quotient)
- 1100 REMU (remainder)
- any other code: Res=0.
REQ-016 An operation is accepted on the rising edge where in_valid && in_ready; A, B and OP are captured internally at that edge.
REQ-017 The FSM has three states:
- IDLE: in_ready=1, out_valid=0.
- BUSY: in_ready=0, out_valid=0.
- DONE: out_valid=1, in_ready=out_ready.
REQ-018 Single-cycle ops (every code except 1010/1011/1100): an accept in IDLE goes to DONE; the result is visible from the next cycle (latency 1).
REQ-019 Multi-cycle ops (1010/1011/1100): an accept goes to BUSY; the counter loads WIDTH and decrements once per cycle.
REQ-020 When the counter reaches 0 the FSM goes to DONE, so the result is visible exactly WIDTH+1 cycles after accept.
REQ-021 MUL uses a shift-add iteration: one multiplier bit per cycle, with a 2*WIDTH accumulator.
REQ-022 DIVU/REMU use restoring division, one quotient bit per cycle.
REQ-023 Divide by zero (B==0): DIVU returns all ones and REMU returns A; the latency is still WIDTH+1 (no early exit).
REQ-024 Arithmetic wraps modulo 2^WIDTH.
REQ-025 ovf for ADD = A[msb]==B[msb] && Res[msb]!=A[msb].
REQ-026 ovf for SUB = A[msb]!=B[msb] && Res[msb]!=A[msb].
REQ-027 In DONE, Res, zero and ovf stay stable while out_ready=0, for any number of cycles.
REQ-028 In DONE with out_ready=1 and in_valid=0: the result retires and the FSM goes to IDLE.
REQ-029 In DONE with out_ready=1 and in_valid=1: the result retires and the new op is accepted in the same cycle.
- The next state is DONE or BUSY according to the new opcode.
- This gives a sustained throughput of one single-cycle op per clock.
REQ-030 In BUSY, in_valid is ignored and out_ready has no effect.
REQ-031 Res, zero and ovf change only on a transition into DONE.

Reset
REQ-032 While reset=1 at a clock edge, the FSM goes to IDLE.
REQ-033 While reset=1 at a clock edge, the registered outputs clear: Res=0, zero=1, ovf=0, out_valid=0.
REQ-034 While reset=1 at a clock edge, the counter and accumulators clear.
REQ-035 After reset, in_ready=1 from the first cycle with reset=0.
REQ-036 Reset takes priority over any handshake in the same cycle.
REQ-037 Reset asserted during BUSY or DONE discards the operation in flight; no out_valid is produced for it.

Verification (WIDTH=32)
REQ-038 ADD A=FFFFFFFF B=00000001 -> one cycle after accept: Res=0, zero=1, ovf=0.
REQ-039 SUB A=80000000 B=00000001 -> Res=7FFFFFFF, ovf=1, zero=0.
REQ-040 SLT A=FFFFFFFF B=00000001 -> Res=1; the same operands with SLTU -> Res=0.
REQ-041 MUL A=7 B=6 accepted at cycle T:
- in_ready=0 for cycles T+1..T+32.
- out_valid=1 at T+33 with Res=42.
- With out_ready held 0 for 5 cycles, Res stays 42 and out_valid stays 1.
REQ-042 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 100/0 -> FFFFFFFF; REMU 100/0 -> 100.
REQ-043 Reset pulse 1 cycle at T+10 of a DIVU -> out_valid=0, Res=0, in_ready=1 at T+11; a back-to-back stream of ADD ops with out_ready=1 completes one per clock.
